// File: rtl/tnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tnn_pkg
// Description : Shared definitions for the TNN threshold neuron: state
//               encoding, comparison-mode constants and accumulator width.
// Revision    : 1.0 - initial release
// ============================================================================
package tnn_pkg;

    // Controller state encoding
    typedef logic [1:0] tnn_state_t;
    localparam tnn_state_t ST_ACCUM = 2'd0;
    localparam tnn_state_t ST_DRAIN = 2'd1;
    localparam tnn_state_t ST_RESP  = 2'd2;

    // Comparison modes selected by CMP_GT
    localparam int c_CMP_GE = 0;
    localparam int c_CMP_GT = 1;

    // Smallest width that holds a full frame of all-ones operands
    function automatic int acc_width(input int w, input int n, input int max_beats);
        return $clog2(n * max_beats * ((1 << w) - 1) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tnn_operand_adder.sv
`default_nettype none
// ============================================================================
// Module      : tnn_operand_adder
// Description : Combinational N-input adder; each W-bit operand is
//               zero-extended to ACC_W bits before summation.
// Revision    : 1.0 - initial release
// ============================================================================
module tnn_operand_adder #(
    parameter int W     = 3,
    parameter int N     = 2,
    parameter int ACC_W = 6
) (
    input  logic [N*W-1:0]   i_operands,
    output logic [ACC_W-1:0] o_sum
);

    logic [ACC_W-1:0] w_ext [N];
    logic [ACC_W-1:0] w_sum;

    generate
        for (genvar k = 0; k < N; k++) begin : g_ext
            assign w_ext[k] = ACC_W'(i_operands[k*W +: W]);
        end
    endgenerate

    // Sum all zero-extended operands of one beat
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = w_sum + w_ext[k];
        end
    end

    assign o_sum = w_sum;

endmodule
`default_nettype wire

// File: rtl/tnn_threshold_accum.sv
`default_nettype none
// ============================================================================
// Module      : tnn_threshold_accum
// Description : Streaming threshold neuron. Accumulates the operands of a
//               multi-beat frame, compares the total against a threshold
//               latched on the first beat, and reports a fire decision over
//               a valid/ready handshake.
//               Optional macro TNN_EARLY_EXIT_EN: freeze the accumulator and
//               drain the rest of the frame once the comparison is met.
// Revision    : 1.0 - initial release
// ============================================================================
module tnn_threshold_accum
    import tnn_pkg::*;
#(
    parameter  int W         = 3,
    parameter  int N         = 2,
    parameter  int MAX_BEATS = 4,
    parameter  int CMP_GT    = 0,
    localparam int c_ACC_W   = acc_width(W, N, MAX_BEATS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*W-1:0]     in_data,
    input  logic               in_last,
    input  logic [c_ACC_W-1:0] in_thr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_fire,
    output logic [c_ACC_W-1:0] out_sum,
    output logic               out_err
);

    localparam int c_CNT_W = $clog2(MAX_BEATS + 1);

`ifdef TNN_EARLY_EXIT_EN
    localparam bit c_EARLY_EXIT = 1'b1;
`else
    localparam bit c_EARLY_EXIT = 1'b0;
`endif

    tnn_state_t         r_state;
    logic [c_ACC_W-1:0] r_acc;
    logic [c_ACC_W-1:0] r_thr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_fire;
    logic               r_err;

    logic [c_ACC_W-1:0] w_beat_sum;
    logic               w_first;
    logic [c_ACC_W-1:0] w_acc_next;
    logic [c_ACC_W-1:0] w_thr_cur;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_meets;

    tnn_operand_adder #(
        .W     (W),
        .N     (N),
        .ACC_W (c_ACC_W)
    ) u_adder (
        .i_operands (in_data),
        .o_sum      (w_beat_sum)
    );

    // Next accumulator / threshold / count for a beat accepted in ACCUM;
    // a zero beat count marks the first beat of a frame.
    always_comb begin
        w_first    = (r_cnt == '0);
        w_acc_next = w_first ? w_beat_sum : (r_acc + w_beat_sum);
        w_thr_cur  = w_first ? in_thr : r_thr;
        w_cnt_next = w_first ? c_CNT_W'(1) : (r_cnt + c_CNT_W'(1));
        if (CMP_GT == c_CMP_GT) begin
            w_meets = (w_acc_next > w_thr_cur);
        end else begin
            w_meets = (w_acc_next >= w_thr_cur);
        end
    end

    // Frame controller: accumulate, drain overflow/early-exit beats, respond
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_thr   <= '0;
            r_cnt   <= '0;
            r_fire  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        r_acc  <= w_acc_next;
                        r_thr  <= w_thr_cur;
                        r_cnt  <= w_cnt_next;
                        r_fire <= w_meets;
                        if (in_last) begin
                            r_state <= ST_RESP;
                        end else if (w_cnt_next == c_CNT_W'(MAX_BEATS)) begin
                            r_err   <= 1'b1;
                            r_state <= ST_DRAIN;
                        end else if (c_EARLY_EXIT && w_meets) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (in_valid && in_last) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        r_state <= ST_ACCUM;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    // Handshake flags decode the registered state only
    assign in_ready  = (r_state != ST_RESP);
    assign out_valid = (r_state == ST_RESP);
    assign out_fire  = r_fire;
    assign out_sum   = r_acc;
    assign out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tnn_threshold_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_tnn_threshold_accum
// Description : Self-checking bench for tnn_threshold_accum: directed and
//               random frames, scoreboard queue filled by the driver and
//               drained by an independent output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tnn_threshold_accum;

    localparam int W         = 3;
    localparam int N         = 2;
    localparam int MAX_BEATS = 4;
    localparam int CMP_GT    = 0;
    localparam int ACC_W     = $clog2(N * MAX_BEATS * ((1 << W) - 1) + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   in_data;
    logic             in_last;
    logic [ACC_W-1:0] in_thr;
    logic             out_valid;
    logic             out_ready;
    logic             out_fire;
    logic [ACC_W-1:0] out_sum;
    logic             out_err;

    tnn_threshold_accum #(
        .W         (W),
        .N         (N),
        .MAX_BEATS (MAX_BEATS),
        .CMP_GT    (CMP_GT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_thr    (in_thr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fire  (out_fire),
        .out_sum   (out_sum),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             fire;
        logic [ACC_W-1:0] sum;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic stall    = 1'b0;

    // Current frame description
    int               fr_n;
    logic [ACC_W-1:0] fr_thr;
    int               fr_ops [16][N];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit meets(input int acc, input int thr);
        return (CMP_GT != 0) ? (acc > thr) : (acc >= thr);
    endfunction

    // Reference: walk the beats, stopping accumulation at the last beat,
    // at the beat limit (error) or, with early exit, once the threshold holds.
    function automatic exp_t model();
        exp_t e;
        int   acc;
        acc   = 0;
        e.err = 1'b0;
        for (int i = 0; i < fr_n; i++) begin
            for (int k = 0; k < N; k++) acc += fr_ops[i][k];
            if (i == fr_n - 1) break;
            if (i + 1 == MAX_BEATS) begin
                e.err = 1'b1;
                break;
            end
`ifdef TNN_EARLY_EXIT_EN
            if (meets(acc, int'(fr_thr))) break;
`endif
        end
        e.fire = meets(acc, int'(fr_thr));
        e.sum  = ACC_W'(acc);
        return e;
    endfunction

    // Consumer back-pressure
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor
    logic pv, pr;
    exp_t prev_o;
    exp_t got;
    initial begin
        pv = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                check("in_ready_vs_out_valid", in_ready, !out_valid);
                if (out_valid && pv && !pr) begin
                    check("hold_fire", out_fire, prev_o.fire);
                    check("hold_sum",  out_sum,  prev_o.sum);
                    check("hold_err",  out_err,  prev_o.err);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual=1 expected=0 at %0t", $time);
                    end else begin
                        got = sb.pop_front();
                        check("out_fire", out_fire, got.fire);
                        check("out_sum",  out_sum,  got.sum);
                        check("out_err",  out_err,  got.err);
                    end
                end
                pv          = out_valid;
                pr          = out_ready;
                prev_o.fire = out_fire;
                prev_o.sum  = out_sum;
                prev_o.err  = out_err;
            end
        end
    end

    task automatic drive_idle();
        in_valid = 1'b0;
        in_data  = N*W'($urandom);
        in_last  = 1'($urandom);
        in_thr   = ACC_W'($urandom);
    endtask

    task automatic load_beat(input int i);
        in_valid = 1'b1;
        for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(fr_ops[i][k]);
        in_last = (i == fr_n - 1);
        in_thr  = (i == 0) ? fr_thr : ACC_W'($urandom);
    endtask

    // Present beat i, wait for acceptance, check latency after the last beat
    task automatic send_beat(input int i);
        bit ok;
        int t;
        load_beat(i);
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            t++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL beat_accept_timeout actual=0 expected=1 at %0t", $time);
        end
        #1;
        drive_idle();
        if (i == fr_n - 1) begin
            sb.push_back(model());
            @(negedge clk);
            check("latency_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frame();
        for (int i = 0; i < fr_n; i++) send_beat(i);
    endtask

    task automatic set_frame2(input int n, input int thr, input int a0, input int b0,
                              input int a1, input int b1, input int a2, input int b2);
        fr_n   = n;
        fr_thr = ACC_W'(thr);
        fr_ops[0][0] = a0; fr_ops[0][1] = b0;
        fr_ops[1][0] = a1; fr_ops[1][1] = b1;
        fr_ops[2][0] = a2; fr_ops[2][1] = b2;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=1 expected=0");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_fire",  out_fire,  0);
        check("rst_out_sum",   out_sum,   0);
        check("rst_out_err",   out_err,   0);
        check("rst_in_ready",  in_ready,  1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single beat 3+2 against 5
        set_frame2(1, 5, 3, 2, 0, 0, 0, 0);
        run_frame();
        // Three beats summing to 29 against 30, then a frame with its own threshold
        set_frame2(3, 30, 7, 7, 7, 7, 1, 0);
        run_frame();
        set_frame2(1, 2, 1, 1, 0, 0, 0, 0);
        run_frame();
        // Five all-seven beats overflow the beat limit
        fr_n   = 5;
        fr_thr = ACC_W'(50);
        for (int i = 0; i < 5; i++) for (int k = 0; k < N; k++) fr_ops[i][k] = 7;
        run_frame();
        // Early-exit candidate frame
        set_frame2(3, 4, 3, 2, 7, 7, 1, 1);
        run_frame();

        // Decision held under back-pressure while a beat is offered
        stall = 1'b1;
        set_frame2(2, 9, 2, 3, 4, 1, 0, 0);
        run_frame();
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_in_ready",  in_ready,  0);
            check("stall_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        drive_idle();
        stall = 1'b0;
        set_frame2(1, 1, 0, 1, 0, 0, 0, 0);
        run_frame();

        // Asynchronous reset during beat 2 of 3
        set_frame2(3, 10, 6, 6, 5, 5, 4, 4);
        send_beat(0);
        load_beat(1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_sum",   out_sum,   0);
        check("midrst_in_ready",  in_ready,  1);
        drive_idle();
        @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        set_frame2(2, 8, 1, 2, 3, 2, 0, 0);
        run_frame();

        // Random frames
        for (int f = 0; f < 150; f++) begin
            fr_n   = $urandom_range(1, 6);
            fr_thr = ACC_W'($urandom_range(0, 60));
            for (int i = 0; i < fr_n; i++)
                for (int k = 0; k < N; k++) fr_ops[i][k] = $urandom_range(0, 7);
            run_frame();
        end

        begin
            int t;
            t = 0;
            while (sb.size() != 0 && t < 200) begin
                @(posedge clk);
                t++;
            end
            check("scoreboard_drained", sb.size(), 0);
        end
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
